// File: rtl/mem_arbiter_pkg.sv
// Shared types and default bus widths for the memory arbiter and the caches
// that connect to it.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_LINE_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        GNT_IC,
        GNT_DC,
        RESP_IC,
        RESP_DC
    } arb_state_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } requester_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: bit 0 is the IC, bit 1 the DC.
// On a conflict the requester that was not granted last wins.
module mem_arbiter_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  requester_t i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        // NOTE: every branch assigns o_grant, and the default arm closes the case, so no latch.
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last == REQ_DC) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between the I-cache and the D-cache,
// serialising line transactions with a round-robin FSM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int LINE_W     = MEM_LINE_W,
    parameter bit RR_INIT_DC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_busy,

    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_busy,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata
);

    // Seeding "last" with the other requester makes the chosen one win the first conflict.
    localparam requester_t LAST_RST = RR_INIT_DC ? REQ_IC : REQ_DC;

    arb_state_t        r_state,      w_state_nxt;
    requester_t        r_last_grant, w_last_grant_nxt;
    logic              r_mem_req,    w_mem_req_nxt;
    logic              r_mem_we,     w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [LINE_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic [LINE_W-1:0] r_ic_rdata,   w_ic_rdata_nxt;
    logic [LINE_W-1:0] r_dc_rdata,   w_dc_rdata_nxt;
    logic [1:0]        w_grant;

    mem_arbiter_rr_arb2 u_rr_arb2 (
        .i_req   ({dc_req, ic_req}),
        .i_last  (r_last_grant),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk) begin
        // NOTE: the line-data registers are cleared too, so a post-reset read of rdata is defined.
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= LAST_RST;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_ic_rdata   <= '0;
            r_dc_rdata   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_ic_rdata   <= w_ic_rdata_nxt;
            r_dc_rdata   <= w_dc_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_ic_rdata_nxt   = r_ic_rdata;
        w_dc_rdata_nxt   = r_dc_rdata;

        unique case (r_state)
            IDLE: begin
                if (w_grant[0]) begin
                    w_state_nxt      = GNT_IC;
                    w_last_grant_nxt = REQ_IC;
                    w_mem_req_nxt    = 1'b1;
                    w_mem_we_nxt     = 1'b0;
                    w_mem_addr_nxt   = ic_addr;
                    w_mem_wdata_nxt  = '0;
                end else if (w_grant[1]) begin
                    w_state_nxt      = GNT_DC;
                    w_last_grant_nxt = REQ_DC;
                    w_mem_req_nxt    = 1'b1;
                    w_mem_we_nxt     = dc_we;
                    w_mem_addr_nxt   = dc_addr;
                    w_mem_wdata_nxt  = dc_wdata;
                end
            end
            // mem_addr/mem_wdata keep their last value after the ack; only req/we drop.
            GNT_IC: begin
                if (mem_ack) begin
                    w_state_nxt    = RESP_IC;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_ic_rdata_nxt = mem_rdata;
                end
            end
            GNT_DC: begin
                if (mem_ack) begin
                    w_state_nxt    = RESP_DC;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_dc_rdata_nxt = mem_rdata;
                end
            end
            RESP_IC, RESP_DC: w_state_nxt = IDLE;
            default:          w_state_nxt = IDLE;
        endcase
    end

    assign ic_ack    = (r_state == RESP_IC);
    assign dc_ack    = (r_state == RESP_DC);
    assign ic_busy   = ic_req & ~ic_ack;
    assign dc_busy   = dc_req & ~dc_ack;
    assign ic_rdata  = r_ic_rdata;
    assign dc_rdata  = r_dc_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level round-robin model.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_ack;
    logic [127:0] ic_rdata;
    logic         ic_busy;
    logic         dc_req;
    logic         dc_we;
    logic [31:0]  dc_addr;
    logic [127:0] dc_wdata;
    logic         dc_ack;
    logic [127:0] dc_rdata;
    logic         dc_busy;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ack;
    logic [127:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_arbiter #(.ADDR_W(32), .LINE_W(128), .RR_INIT_DC(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ack    (ic_ack),
        .ic_rdata  (ic_rdata),
        .ic_busy   (ic_busy),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_ack    (dc_ack),
        .dc_rdata  (dc_rdata),
        .dc_busy   (dc_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Drive and sample point: 3 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ic_req    = 1'b0;
        ic_addr   = '0;
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        dc_addr   = '0;
        dc_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_mem_req(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({mem_req, mem_we, ic_ack, dc_ack} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got req/we/ic_ack/dc_ack=%b exp 0000", {mem_req, mem_we, ic_ack, dc_ack});
        end
        tests_run++;
        if (mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h exp 0", mem_addr, mem_wdata);
        end
        tests_run++;
        if (ic_rdata !== 128'h0 || dc_rdata !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got ic=%h dc=%h exp 0", ic_rdata, dc_rdata);
        end
    endtask

    task automatic test_ic_read();
        logic [127:0] line = {16{8'hA5}};
        ic_addr = 32'h100;
        ic_req  = 1'b1;
        step();
        tests_run++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h100, 128'h0}) begin
            tests_failed++;
            $display("FAIL ic_rd_grant: got req=%b we=%b addr=%h wdata=%h exp 1 0 100 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({mem_req, ic_busy, ic_ack, dc_ack, mem_addr} !== {4'b1100, 32'h100}) begin
                tests_failed++;
                $display("FAIL ic_rd_hold: got req=%b busy=%b ic_ack=%b dc_ack=%b addr=%h exp 1 1 0 0 100",
                         mem_req, ic_busy, ic_ack, dc_ack, mem_addr);
            end
            step();
        end
        mem_ack   = 1'b1;
        mem_rdata = line;
        step();
        mem_ack = 1'b0;
        tests_run++;
        if ({ic_ack, dc_ack, mem_req, ic_busy} !== 4'b1000 || ic_rdata !== line) begin
            tests_failed++;
            $display("FAIL ic_rd_ack: got ic_ack=%b dc_ack=%b req=%b busy=%b rdata=%h exp 1 0 0 0 %h",
                     ic_ack, dc_ack, mem_req, ic_busy, ic_rdata, line);
        end
        ic_req = 1'b0;
        step();
        tests_run++;
        if (ic_ack !== 1'b0 || ic_rdata !== line) begin
            tests_failed++;
            $display("FAIL ic_rd_after: got ic_ack=%b rdata=%h exp 0 %h", ic_ack, ic_rdata, line);
        end
    endtask

    task automatic test_dc_writeback();
        dc_we    = 1'b1;
        dc_addr  = 32'h2000;
        dc_wdata = 128'h1234;
        dc_req   = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h2000, 128'h1234}) begin
                tests_failed++;
                $display("FAIL dc_wb_hold: got req=%b we=%b addr=%h wdata=%h exp 1 1 2000 1234",
                         mem_req, mem_we, mem_addr, mem_wdata);
            end
            if (i < 2) step();
        end
        mem_ack   = 1'b1;
        mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        step();
        mem_ack = 1'b0;
        tests_run++;
        if ({dc_ack, ic_ack, mem_req, mem_we, dc_busy} !== 5'b10000) begin
            tests_failed++;
            $display("FAIL dc_wb_ack: got dc_ack=%b ic_ack=%b req=%b we=%b busy=%b exp 1 0 0 0 0",
                     dc_ack, ic_ack, mem_req, mem_we, dc_busy);
        end
        dc_req = 1'b0;
        dc_we  = 1'b0;
        step();
        tests_run++;
        if ({dc_ack, mem_we} !== 2'b00) begin
            tests_failed++;
            $display("FAIL dc_wb_after: got dc_ack=%b we=%b exp 0 0", dc_ack, mem_we);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [127:0] line_dc = {4{32'hDCDC_0001}};
        logic [127:0] line_ic = {4{32'h1C1C_0002}};
        do_reset();
        ic_addr = 32'h4000;
        dc_addr = 32'h3000;
        dc_we   = 1'b0;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        step();
        tests_run++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h3000}) begin
            tests_failed++;
            $display("FAIL sim_first_dc: got req=%b addr=%h exp 1 3000", mem_req, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({ic_busy, ic_ack} !== 2'b10) begin
                tests_failed++;
                $display("FAIL sim_ic_stall: got busy=%b ic_ack=%b exp 1 0", ic_busy, ic_ack);
            end
        end
        mem_ack   = 1'b1;
        mem_rdata = line_dc;
        step();
        mem_ack = 1'b0;
        tests_run++;
        if ({dc_ack, ic_ack, ic_busy} !== 3'b101 || dc_rdata !== line_dc) begin
            tests_failed++;
            $display("FAIL sim_dc_ack: got dc_ack=%b ic_ack=%b ic_busy=%b rdata=%h exp 1 0 1 %h",
                     dc_ack, ic_ack, ic_busy, dc_rdata, line_dc);
        end
        dc_req = 1'b0;
        wait_mem_req(10, ok);
        tests_run++;
        if (!ok || mem_addr !== 32'h4000 || mem_we !== 1'b0 || ic_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sim_then_ic: got seen=%b addr=%h we=%b busy=%b exp 1 4000 0 1",
                     ok, mem_addr, mem_we, ic_busy);
        end
        mem_ack   = 1'b1;
        mem_rdata = line_ic;
        step();
        mem_ack = 1'b0;
        tests_run++;
        if (ic_ack !== 1'b1 || ic_rdata !== line_ic || dc_rdata !== line_dc) begin
            tests_failed++;
            $display("FAIL sim_ic_ack: got ic_ack=%b ic_rdata=%h dc_rdata=%h exp 1 %h %h",
                     ic_ack, ic_rdata, dc_rdata, line_ic, line_dc);
        end
        ic_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit exp_dc = 1'b1;
        int lat;
        do_reset();
        ic_addr = 32'h1000;
        dc_addr = 32'h9000;
        dc_we   = 1'b0;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wait_mem_req(10, ok);
            tests_run++;
            if (!ok || mem_addr[15] !== exp_dc) begin
                tests_failed++;
                $display("FAIL b2b_order_%0d: got seen=%b dc=%b exp 1 %b", n, ok, mem_addr[15], exp_dc);
            end
            lat = $urandom_range(1, 4);
            for (int i = 1; i < lat; i++) step();
            mem_ack   = 1'b1;
            mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            mem_ack = 1'b0;
            tests_run++;
            if ({dc_ack, ic_ack} !== (exp_dc ? 2'b10 : 2'b01)) begin
                tests_failed++;
                $display("FAIL b2b_ack_%0d: got dc_ack/ic_ack=%b%b exp %b", n, dc_ack, ic_ack,
                         exp_dc ? 2'b10 : 2'b01);
            end
            if (exp_dc) dc_addr = dc_addr + 32'h10;
            else        ic_addr = ic_addr + 32'h10;
            exp_dc = !exp_dc;
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        logic [127:0] line = {4{32'h5EED_0005}};
        ic_addr = 32'h500;
        ic_req  = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if ({mem_req, ic_ack} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_mid_drop: got req=%b ic_ack=%b exp 0 0", mem_req, ic_ack);
        end
        reset = 1'b0;
        step();
        tests_run++;
        if ({mem_req, ic_ack, mem_addr} !== {2'b10, 32'h500}) begin
            tests_failed++;
            $display("FAIL rst_mid_regrant: got req=%b ic_ack=%b addr=%h exp 1 0 500", mem_req, ic_ack, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = line;
        step();
        mem_ack = 1'b0;
        tests_run++;
        if (ic_ack !== 1'b1 || ic_rdata !== line) begin
            tests_failed++;
            $display("FAIL rst_mid_serve: got ic_ack=%b rdata=%h exp 1 %h", ic_ack, ic_rdata, line);
        end
        ic_req = 1'b0;
        step();
    endtask

    task automatic test_spurious_ack();
        logic [31:0]  old_addr = mem_addr;
        logic [127:0] old_ic   = ic_rdata;
        logic [127:0] old_dc   = dc_rdata;
        mem_ack   = 1'b1;
        mem_rdata = ~old_ic;
        step();
        mem_ack = 1'b0;
        step();
        tests_run++;
        if ({ic_ack, dc_ack, mem_req, mem_we} !== 4'b0000 || mem_addr !== old_addr ||
            ic_rdata !== old_ic || dc_rdata !== old_dc) begin
            tests_failed++;
            $display("FAIL spurious_ignored: got acks=%b%b req=%b we=%b addr=%h ic=%h dc=%h exp 0 0 0 0 %h %h %h",
                     ic_ack, dc_ack, mem_req, mem_we, mem_addr, ic_rdata, dc_rdata, old_addr, old_ic, old_dc);
        end
        dc_addr = 32'h600;
        dc_we   = 1'b0;
        dc_req  = 1'b1;
        step();
        tests_run++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
            tests_failed++;
            $display("FAIL spurious_still_idle: got req=%b addr=%h exp 1 600", mem_req, mem_addr);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        dc_req  = 1'b0;
        step();
    endtask

    // Transaction-level model: a grant goes to the only requester that was
    // asking, or on a conflict to the one not granted most recently.
    task automatic test_random();
        localparam int N = 30;
        int ic_done = 0, dc_done = 0, mem_cnt = 0, mem_lat = 0;
        int ic_wait = 0, dc_wait = 0, cyc = 0;
        bit ic_pend = 0, dc_pend = 0, prev_ic = 0, prev_dc = 0;
        bit ic_due = 0, dc_due = 0, mem_busy = 0, owner_dc = 0, last_dc = 0;
        bit timed_out = 0;
        logic         tx_we;
        logic [31:0]  tx_addr;
        logic [127:0] tx_wdata, ic_line, dc_line;
        tx_we = 1'b0; tx_addr = '0; tx_wdata = '0; ic_line = '0; dc_line = '0;
        do_reset();
        while ((ic_done < N || dc_done < N || ic_pend || dc_pend) && cyc < 20000) begin
            step();
            cyc++;
            mem_ack = 1'b0;
            tests_run++;
            if ({ic_ack, dc_ack} !== {ic_due, dc_due}) begin
                tests_failed++;
                $display("FAIL rand_ack cyc %0d: got ic/dc ack=%b%b exp %b%b", cyc, ic_ack, dc_ack, ic_due, dc_due);
            end
            tests_run++;
            if ({ic_busy, dc_busy} !== {ic_pend && !ic_due, dc_pend && !dc_due}) begin
                tests_failed++;
                $display("FAIL rand_busy cyc %0d: got ic/dc busy=%b%b exp %b%b", cyc, ic_busy, dc_busy,
                         ic_pend && !ic_due, dc_pend && !dc_due);
            end
            if (ic_due) begin
                tests_run++;
                if (ic_rdata !== ic_line) begin
                    tests_failed++;
                    $display("FAIL rand_ic_rdata cyc %0d: got %h exp %h", cyc, ic_rdata, ic_line);
                end
                ic_pend = 0; ic_done++; ic_wait = 0;
            end
            if (dc_due) begin
                tests_run++;
                if (dc_rdata !== dc_line) begin
                    tests_failed++;
                    $display("FAIL rand_dc_rdata cyc %0d: got %h exp %h", cyc, dc_rdata, dc_line);
                end
                dc_pend = 0; dc_done++; dc_wait = 0;
            end
            ic_due = 0;
            dc_due = 0;

            if (mem_req === 1'b1 && !mem_busy) begin
                bit exp_dc;
                exp_dc   = (prev_ic && prev_dc) ? !last_dc : prev_dc;
                tx_we    = exp_dc ? dc_we : 1'b0;
                tx_addr  = exp_dc ? dc_addr : ic_addr;
                tx_wdata = exp_dc ? dc_wdata : 128'h0;
                tests_run++;
                if (!(prev_ic || prev_dc) || mem_addr !== tx_addr) begin
                    tests_failed++;
                    $display("FAIL rand_grant cyc %0d: got addr=%h exp %h (pending ic=%b dc=%b)",
                             cyc, mem_addr, tx_addr, prev_ic, prev_dc);
                end
                owner_dc = exp_dc;
                last_dc  = exp_dc;
                mem_busy = 1'b1;
                mem_cnt  = 0;
                mem_lat  = $urandom_range(1, 4);
            end

            if (mem_busy) begin
                tests_run++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, tx_we, tx_addr, tx_wdata}) begin
                    tests_failed++;
                    $display("FAIL rand_mem_bus cyc %0d: got req=%b we=%b addr=%h wdata=%h exp 1 %b %h %h",
                             cyc, mem_req, mem_we, mem_addr, mem_wdata, tx_we, tx_addr, tx_wdata);
                end
                mem_cnt++;
                if (mem_cnt == mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                    if (owner_dc) begin dc_line = mem_rdata; dc_due = 1; end
                    else          begin ic_line = mem_rdata; ic_due = 1; end
                    mem_busy = 1'b0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            end

            if (!ic_pend && ic_done < N && $urandom_range(0, 2) == 0) begin
                ic_pend = 1;
                ic_addr = $urandom() & 32'h7FFF_FFF0;
                ic_req  = 1'b1;
            end else if (!ic_pend) begin
                ic_req  = 1'b0;
                ic_addr = $urandom();
            end
            if (!dc_pend && dc_done < N && $urandom_range(0, 2) == 0) begin
                dc_pend  = 1;
                dc_we    = 1'($urandom_range(0, 1));
                dc_addr  = ($urandom() | 32'h8000_0000) & 32'hFFFF_FFF0;
                dc_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
                dc_req   = 1'b1;
            end else if (!dc_pend) begin
                dc_req = 1'b0;
            end
            if (ic_pend) ic_wait++;
            if (dc_pend) dc_wait++;
            if (ic_wait > 40 || dc_wait > 40) begin
                timed_out = 1'b1;
                break;
            end
            prev_ic = ic_req;
            prev_dc = dc_req;
        end
        tests_run++;
        if (timed_out || ic_done != N || dc_done != N) begin
            tests_failed++;
            $display("FAIL rand_complete: got ic=%0d dc=%0d stalled=%b after %0d cycles exp %0d %0d 0",
                     ic_done, dc_done, timed_out, cyc, N, N);
        end
        ic_req  = 1'b0;
        dc_req  = 1'b0;
        mem_ack = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ic_read();
        test_dc_writeback();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
